utm_engine: RTL and testbench

Parametrised, self-contained Turing-machine engine and successor to the fixed 3-bit-state/3-bit-symbol UTM core, whose host supplies the tape and gets back one transition per clock. This engine holds a programmable transition table and an on-chip tape, and runs autonomously from `start` until it halts, walks off the tape, saturates its step counter or is aborted. It sits behind the top-level I/O wrapper, which drives the programming, tape-load and run controls.

---
 rtl/utm_engine.sv | 103 ++++++++++
 tb/tb_utm_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/utm_engine.sv
// utm_engine: programmable-table Turing machine with on-chip tape, one step per READ/EXEC cycle pair
// Ports: clock/reset; prog_we/prog_state/prog_sym/prog_data write a table entry {next_state, new_sym, dir};
//        tape_we/tape_addr/tape_wdata/tape_rdata give host access to the tape; start/abort control a run;
//        busy/done/status/state_out/head_out/step_count report progress and the result.
module utm_engine #(
  parameter int STATE_BITS = 3,
  parameter int SYM_BITS = 3,
  parameter int TAPE_LEN = 16,
  parameter int STEP_BITS = 16,
  localparam int AW = $clog2(TAPE_LEN),
  localparam int EW = STATE_BITS + SYM_BITS + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [STATE_BITS-1:0] prog_state,
  input  logic [SYM_BITS-1:0]   prog_sym,
  input  logic [EW-1:0]         prog_data,
  input  logic                  tape_we,
  input  logic [AW-1:0]         tape_addr,
  input  logic [SYM_BITS-1:0]   tape_wdata,
  output logic [SYM_BITS-1:0]   tape_rdata,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            status,
  output logic [STATE_BITS-1:0] state_out,
  output logic [AW-1:0]         head_out,
  output logic [STEP_BITS-1:0]  step_count
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} fsm_t;
  fsm_t r_fsm, w_fsm_n;
  logic [EW-1:0] r_table [2**(STATE_BITS+SYM_BITS)];
  logic [SYM_BITS-1:0] r_tape [TAPE_LEN];
  logic [STATE_BITS-1:0] r_state;
  logic [AW-1:0] r_head;
  logic [STEP_BITS-1:0] r_step;
  logic [1:0] r_status;
  logic [SYM_BITS-1:0] r_sym, r_rdata;
  logic [STATE_BITS-1:0] w_ns;
  logic [SYM_BITS-1:0] w_nsym;
  logic w_dir, w_oob, w_halt, w_sat, w_host, w_exec, w_run;
  logic [STEP_BITS-1:0] w_step_n;
  assign {w_ns, w_nsym, w_dir} = r_table[{r_state, r_sym}];
  assign w_halt = w_ns == '1;
  // a move that would leave the tape ends the run instead of wrapping the head
  assign w_oob = w_dir ? r_head == '1 : r_head == '0;
  assign w_step_n = r_step + STEP_BITS'(1);
  assign w_sat = w_step_n == '1;
  assign w_run = r_fsm == READ || r_fsm == EXEC;
  assign w_host = !w_run;
  // abort pre-empts the step sampled in the same cycle
  assign w_exec = r_fsm == EXEC && !abort;
  assign tape_rdata = r_rdata;
  assign status = r_status;
  assign state_out = r_state;
  assign head_out = r_head;
  assign step_count = r_step;
  always_comb begin
    w_fsm_n = r_fsm;
    busy = w_run;
    done = r_fsm == DONE;
    case (r_fsm)
      IDLE: w_fsm_n = start ? READ : IDLE;
      READ: w_fsm_n = abort ? DONE : EXEC;
      EXEC: w_fsm_n = abort || w_halt || w_oob || w_sat ? DONE : READ;
      default: w_fsm_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) r_fsm <= reset ? IDLE : w_fsm_n;
  always_ff @(posedge clock) begin
    if (prog_we && w_host) r_table[{prog_state, prog_sym}] <= prog_data;
    if (tape_we && w_host) r_tape[tape_addr] <= tape_wdata;
    else if (w_exec && !reset) r_tape[r_head] <= w_nsym;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
      r_state <= '0;
      r_head <= '0;
      r_step <= '0;
      r_status <= '0;
      r_sym <= '0;
    end else begin
      r_rdata <= r_tape[tape_addr];
      if (r_fsm == IDLE && start) begin
        r_state <= '0;
        r_head <= '0;
        r_step <= '0;
        r_status <= '0;
      end
      if (r_fsm == READ) r_sym <= r_tape[r_head];
      if (w_run && abort) r_status <= 2'd3;
      if (w_exec) begin
        r_state <= w_ns;
        r_step <= w_step_n;
        if (!w_oob) r_head <= w_dir ? r_head + AW'(1) : r_head - AW'(1);
        if (w_halt || w_oob || w_sat) r_status <= w_halt ? 2'd0 : w_oob ? 2'd1 : 2'd2;
      end
    end
  end
endmodule

// File: tb/tb_utm_engine.sv
// tb_utm_engine: table-driven and scoreboard checks of utm_engine runs, tape contents and control corners
module tb_utm_engine;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, prog_we, tape_we, start0, start1, abort;
  logic [2:0] prog_state, prog_sym, tape_wdata;
  logic [6:0] prog_data;
  logic [3:0] tape_addr;
  logic [2:0] rd0, rd1, st0, st1;
  logic busy0, busy1, done0, done1;
  logic [1:0] status0, status1;
  logic [3:0] hd0, hd1, sc1;
  logic [15:0] sc0;
  utm_engine u0 (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_state(prog_state), .prog_sym(prog_sym),
    .prog_data(prog_data), .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata),
    .tape_rdata(rd0), .start(start0), .abort(abort), .busy(busy0), .done(done0), .status(status0),
    .state_out(st0), .head_out(hd0), .step_count(sc0)
  );
  utm_engine #(.STEP_BITS(4)) u1 (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_state(prog_state), .prog_sym(prog_sym),
    .prog_data(prog_data), .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata),
    .tape_rdata(rd1), .start(start1), .abort(abort), .busy(busy1), .done(done1), .status(status1),
    .state_out(st1), .head_out(hd1), .step_count(sc1)
  );
  typedef struct {
    logic [1:0] status;
    logic [2:0] state;
    logic [3:0] head;
    logic [15:0] step;
    int busy;
  } res_t;
  typedef struct {
    logic [6:0] entry;
    logic [2:0] t0;
    logic [2:0] trest;
    res_t exp;
  } vec_t;
  res_t q[$];
  logic [2:0] tq[$];
  int n_tests = 0;
  int n_fail = 0;
  vec_t v[3];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic prog(input logic [2:0] s, input logic [2:0] y, input logic [6:0] d);
    @(negedge clock);
    prog_we = 1'b1;
    prog_state = s;
    prog_sym = y;
    prog_data = d;
    @(negedge clock);
    prog_we = 1'b0;
  endtask
  task automatic fill_tape(input logic [2:0] val);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      tape_we = 1'b1;
      tape_addr = 4'(i);
      tape_wdata = val;
    end
    @(negedge clock);
    tape_we = 1'b0;
  endtask
  task automatic check_tape(input string name, input logic [2:0] t0, input logic [2:0] trest);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      tape_addr = 4'(i);
      tq.push_back(i == 0 ? t0 : trest);
      @(negedge clock);
      chk(name, 32'(rd0), 32'(tq.pop_front()));
    end
  endtask
  task automatic run(input bit sel, input int abort_at, input res_t e);
    int n;
    bit seen;
    res_t x;
    n = 0;
    seen = 1'b0;
    q.push_back(e);
    @(negedge clock);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    start1 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (sel ? done1 : done0) begin
        seen = 1'b1;
        break;
      end
      if (sel ? busy1 : busy0) n++;
      abort = abort_at != 0 && n == abort_at;
      @(negedge clock);
    end
    abort = 1'b0;
    x = q.pop_front();
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_cycles", 32'(n), 32'(x.busy));
    chk("status", 32'(sel ? status1 : status0), 32'(x.status));
    chk("state_out", 32'(sel ? st1 : st0), 32'(x.state));
    chk("head_out", 32'(sel ? hd1 : hd0), 32'(x.head));
    chk("step_count", sel ? 32'(sc1) : 32'(sc0), 32'(x.step));
    @(negedge clock);
    chk("done_width", 32'(sel ? done1 : done0), 32'd0);
    chk("busy_after", 32'(sel ? busy1 : busy0), 32'd0);
  endtask
  initial begin
    reset = 1'b1;
    prog_we = 1'b0;
    tape_we = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    abort = 1'b0;
    prog_state = '0;
    prog_sym = '0;
    prog_data = '0;
    tape_addr = '0;
    tape_wdata = '0;
    v[0] = '{{3'd7, 3'd5, 1'b1}, 3'd5, 3'd0, '{2'd0, 3'd7, 4'd1, 16'd1, 2}};
    v[1] = '{{3'd0, 3'd1, 1'b1}, 3'd1, 3'd1, '{2'd1, 3'd0, 4'd15, 16'd16, 32}};
    v[2] = '{{3'd0, 3'd2, 1'b0}, 3'd2, 3'd0, '{2'd1, 3'd0, 4'd0, 16'd1, 2}};
    @(negedge clock);
    @(negedge clock);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_status", 32'(status0), 32'd0);
    chk("rst_state", 32'(st0), 32'd0);
    chk("rst_head", 32'(hd0), 32'd0);
    chk("rst_step", 32'(sc0), 32'd0);
    chk("rst_rdata", 32'(rd0), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fill_tape(3'd0);
      prog(3'd0, 3'd0, v[k].entry);
      run(1'b0, 0, v[k].exp);
      check_tape("vec_tape", v[k].t0, v[k].trest);
    end
    fill_tape(3'd0);
    prog(3'd0, 3'd0, {3'd7, 3'd5, 1'b1});
    @(negedge clock);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    prog_we = 1'b1;
    prog_state = 3'd0;
    prog_sym = 3'd0;
    prog_data = {3'd0, 3'd3, 1'b1};
    tape_we = 1'b1;
    tape_addr = 4'd3;
    tape_wdata = 3'd6;
    @(negedge clock);
    prog_we = 1'b0;
    tape_we = 1'b0;
    @(negedge clock);
    chk("ign_done", 32'(done0), 32'd1);
    chk("ign_status", 32'(status0), 32'd0);
    chk("ign_state", 32'(st0), 32'd7);
    check_tape("ign_tape", 3'd5, 3'd0);
    for (int s = 0; s < 8; s++) begin
      prog(3'd0, 3'(s), {3'd1, 3'(s), 1'b1});
      prog(3'd1, 3'(s), {3'd0, 3'(s), 1'b0});
    end
    fill_tape(3'd3);
    run(1'b1, 0, '{2'd2, 3'd1, 4'd1, 16'd15, 30});
    run(1'b0, 3, '{2'd3, 3'd1, 4'd1, 16'd1, 3});
    check_tape("abort_tape", 3'd3, 3'd3);
    fill_tape(3'd0);
    run(1'b0, 2, '{2'd3, 3'd0, 4'd0, 16'd0, 2});
    prog(3'd0, 3'd0, {3'd7, 3'd5, 1'b1});
    @(negedge clock);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_done", 32'(done0), 32'd0);
    chk("mid_rst_status", 32'(status0), 32'd0);
    chk("mid_rst_state", 32'(st0), 32'd0);
    chk("mid_rst_head", 32'(hd0), 32'd0);
    chk("mid_rst_step", 32'(sc0), 32'd0);
    @(negedge clock);
    chk("mid_rst_nodone", 32'(done0), 32'd0);
    check_tape("mid_rst_tape", 3'd0, 3'd0);
    run(1'b0, 0, v[0].exp);
    check_tape("rerun_tape", 3'd5, 3'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
